cpu_ahb2apb_bridge: RTL and testbench

AHB-Lite slave to APB3 master bridge, single clock domain (PCLK = HCLK).
It hangs off the system bus fed by the CPU system master (m2) and drives APB3 peripherals, including the CPU subsystem's own APB register slave.
It converts one AHB data phase into one APB SETUP/ACCESS pair, inserting wait states.
It maps APB slave errors and an optional PREADY timeout onto a two-cycle AHB ERROR response.

---
 rtl/cpu_ahb2apb_bridge_pkg.sv | 25 ++
 rtl/cpu_ahb2apb_bridge_if.sv | 53 +++++
 rtl/cpu_ahb2apb_bridge.sv | 124 ++++++++++++
 tb/tb_cpu_ahb2apb_bridge.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ahb2apb_bridge_pkg.sv
// Shared AHB/APB bus encodings and the bridge state set.
// Imported by the bridge and its bus interfaces.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_e;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_SETUP,
    ST_ACCESS,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } br_state_e;

endpackage

// File: rtl/cpu_ahb2apb_bridge_if.sv
// AHB-Lite and APB3 bus bundles used by the bridge.
// Both are parameterised on address and data width.
interface cpu_ahb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              hsel;
  logic [1:0]        htrans;
  logic [ADDR_W-1:0] haddr;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [DATA_W-1:0] hwdata;
  logic              hready;
  logic              hreadyout;
  logic [1:0]        hresp;
  logic [DATA_W-1:0] hrdata;

  modport master (
    output hsel, htrans, haddr, hwrite,
    output hsize, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, htrans, haddr, hwrite,
    input  hsize, hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

interface cpu_apb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/cpu_ahb2apb_bridge.sv
// AHB-Lite slave to APB3 master bridge, one APB SETUP/ACCESS per AHB
// data phase, with optional PREADY timeout mapped to an AHB ERROR.
module cpu_ahb2apb_bridge
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 0
) (
  input  logic     cpu_hclk,
  input  logic     cpu_hrst_n,
  cpu_ahb_if.slave ahb,
  cpu_apb_if.master apb
);

  localparam int CNT_W =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  br_state_e         state, state_n;
  logic [ADDR_W-1:0] paddr_q;
  logic              pwrite_q;
  logic [DATA_W-1:0] pwdata_q;
  logic [DATA_W-1:0] hrdata_q;
  logic [CNT_W-1:0]  cnt;

  logic accept, can_take, take, ack, tmo;
  logic unused;

  assign unused = ^{ahb.hsize, ahb.htrans[0]};

  assign accept   = ahb.hsel & ahb.hready & ahb.htrans[1];
  assign can_take = (state == ST_IDLE) |
                    (state == ST_DONE) |
                    (state == ST_ERR2);
  assign take     = accept & can_take;
  assign ack      = (state == ST_ACCESS) & apb.pready;
  assign tmo      = (TIMEOUT != 0) & ~apb.pready &
                    (cnt == CNT_LAST);

  always_comb begin
    state_n       = state;
    ahb.hreadyout = 1'b1;
    ahb.hresp     = HRESP_OKAY;
    apb.psel      = 1'b0;
    apb.penable   = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        if (state == ST_ERR2)
          ahb.hresp = HRESP_ERROR;
        if (take)
          state_n = ahb.hwrite ? ST_WDATA : ST_SETUP;
        else
          state_n = ST_IDLE;
      end
      ST_WDATA: begin
        ahb.hreadyout = 1'b0;
        state_n       = ST_SETUP;
      end
      ST_SETUP: begin
        ahb.hreadyout = 1'b0;
        apb.psel      = 1'b1;
        state_n       = ST_ACCESS;
      end
      ST_ACCESS: begin
        ahb.hreadyout = 1'b0;
        apb.psel      = 1'b1;
        apb.penable   = 1'b1;
        if (apb.pready)
          state_n = apb.pslverr ? ST_ERR1 : ST_DONE;
        else if (tmo)
          state_n = ST_ERR1;
      end
      ST_ERR1: begin
        ahb.hreadyout = 1'b0;
        ahb.hresp     = HRESP_ERROR;
        state_n       = ST_ERR2;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge cpu_hclk or negedge cpu_hrst_n) begin
    if (!cpu_hrst_n)
      state <= ST_IDLE;
    else
      state <= state_n;
  end

  always_ff @(posedge cpu_hclk or negedge cpu_hrst_n) begin
    if (!cpu_hrst_n) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      hrdata_q <= '0;
    end else begin
      if (take) begin
        paddr_q  <= ahb.haddr;
        pwrite_q <= ahb.hwrite;
      end
      if (state == ST_WDATA)
        pwdata_q <= ahb.hwdata;
      if (ack & ~apb.pslverr & ~pwrite_q)
        hrdata_q <= apb.prdata;
    end
  end

  // Counts ACCESS cycles; saturates so a stuck slave never wraps it
  always_ff @(posedge cpu_hclk or negedge cpu_hrst_n) begin
    if (!cpu_hrst_n)
      cnt <= '0;
    else if (state_n == ST_SETUP)
      cnt <= '0;
    else if ((state == ST_ACCESS) && (cnt != CNT_MAX))
      cnt <= cnt + CNT_W'(1);
  end

  assign apb.paddr  = paddr_q;
  assign apb.pwrite = pwrite_q;
  assign apb.pwdata = pwdata_q;
  assign ahb.hrdata = hrdata_q;

endmodule

// File: tb/tb_cpu_ahb2apb_bridge.sv
// Bench for cpu_ahb2apb_bridge: directed cases then random transfers
// against a transfer-level timing model and a word memory reference.
module tb_cpu_ahb2apb_bridge;
  import cpu_bus_pkg::*;

  localparam int TMO = 4;
  localparam logic [31:0] BASE = 32'h4000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_ahb_if #(.ADDR_W(32), .DATA_W(32)) ahb ();
  cpu_apb_if #(.ADDR_W(32), .DATA_W(32)) apb ();

  assign ahb.hready = ahb.hreadyout;

  cpu_ahb2apb_bridge #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)
  ) dut (
    .cpu_hclk  (clk),
    .cpu_hrst_n(rst_n),
    .ahb       (ahb),
    .apb       (apb)
  );

  int checks = 0;
  int errors = 0;

  // behavioural APB slave
  logic [31:0] smem [16];
  int acnt = 0;
  int s_waits = 0;
  bit s_err = 0, s_hang = 0, s_noise = 0;

  assign apb.pready  = apb.psel && apb.penable && !s_hang &&
                       (acnt >= s_waits);
  assign apb.pslverr = apb.pready ? s_err : s_noise;
  assign apb.prdata  = smem[apb.paddr[5:2]];

  always @(posedge clk) begin
    if (apb.psel && apb.penable) acnt <= acnt + 1;
    else acnt <= 0;
    if (apb.psel && apb.penable && apb.pready &&
        apb.pwrite && !apb.pslverr)
      smem[apb.paddr[5:2]] <= apb.pwdata;
  end

  // reference state
  logic [31:0] rmem [16];
  logic [31:0] last_rd = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ctl();
    return {27'b0, ahb.hreadyout, ahb.hresp, apb.psel, apb.penable};
  endfunction

  function automatic logic [31:0] mk(input bit rdy, input logic [1:0] rsp,
                                     input bit sel, input bit en);
    return {27'b0, rdy, rsp, sel, en};
  endfunction

  task automatic xfer(input int idx, input bit wr, input logic [31:0] data,
                      input int waits, input bit err, input bit hang,
                      input bit chained, input bit chain_nxt,
                      input int nidx, input bit nwr);
    logic [31:0] addr, exp_rd, e;
    int n, total, o;
    bit error;
    addr  = BASE | (32'(idx) << 2);
    o     = wr ? 1 : 0;
    n     = hang ? TMO : waits + 1;
    error = hang || err;
    total = o + 2 + n + (error ? 1 : 0);
    exp_rd = (!wr && !error) ? rmem[idx] : last_rd;
    s_waits = waits;
    s_err   = err;
    s_hang  = hang;
    s_noise = 1'($urandom);
    if (!chained) begin
      ahb.hsel   = 1'b1;
      ahb.htrans = HT_NONSEQ;
      ahb.haddr  = addr;
      ahb.hwrite = wr;
      @(negedge clk);
      chk("accept_rdy", ctl(), mk(1, HRESP_OKAY, 0, 0));
      @(posedge clk); #1;
    end
    ahb.hsel   = 1'b0;
    ahb.htrans = HT_IDLE;
    ahb.haddr  = $urandom;
    ahb.hwdata = data;
    for (int k = 1; k <= total; k++) begin
      if (k == o + 1) ahb.hwdata = $urandom;
      if (k == total && chain_nxt) begin
        ahb.hsel   = 1'b1;
        ahb.htrans = HT_NONSEQ;
        ahb.haddr  = BASE | (32'(nidx) << 2);
        ahb.hwrite = nwr;
      end
      @(negedge clk);
      if (k <= o) begin
        chk("wdata_ctl", ctl(), mk(0, HRESP_OKAY, 0, 0));
      end else if (k <= o + 1 + n) begin
        e = mk(0, HRESP_OKAY, 1, (k == o + 1) ? 0 : 1);
        chk(k == o + 1 ? "setup_ctl" : "access_ctl", ctl(), e);
        chk("paddr", apb.paddr, addr);
        chk("pwrite", 32'(apb.pwrite), 32'(wr));
        if (wr) chk("pwdata", apb.pwdata, data);
      end else if (k == o + 2 + n && !error) begin
        chk("done_ctl", ctl(), mk(1, HRESP_OKAY, 0, 0));
        chk("hrdata", ahb.hrdata, exp_rd);
      end else if (k == o + 2 + n) begin
        chk("err1_ctl", ctl(), mk(0, HRESP_ERROR, 0, 0));
      end else begin
        chk("err2_ctl", ctl(), mk(1, HRESP_ERROR, 0, 0));
        chk("hrdata_err", ahb.hrdata, exp_rd);
      end
      @(posedge clk); #1;
    end
    if (!error) begin
      if (wr) rmem[idx] = data;
      else last_rd = rmem[idx];
    end
  endtask

  int cidx, nidx, cw, nw;
  bit pend, c;

  initial begin
    ahb.hsel   = 1'b0;
    ahb.htrans = HT_IDLE;
    ahb.haddr  = '0;
    ahb.hwrite = 1'b0;
    ahb.hsize  = 3'b010;
    ahb.hwdata = '0;
    for (int i = 0; i < 16; i++) begin
      rmem[i] = $urandom;
      smem[i] = rmem[i];
    end
    rmem[4] = 32'hDEAD_BEEF;
    smem[4] = 32'hDEAD_BEEF;

    @(negedge clk);
    chk("rst_ctl", ctl(), mk(1, HRESP_OKAY, 0, 0));
    chk("rst_hrdata", ahb.hrdata, 32'h0);
    chk("rst_paddr", apb.paddr, 32'h0);
    chk("rst_pwdata", apb.pwdata, 32'h0);
    chk("rst_pwrite", 32'(apb.pwrite), 32'h0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    xfer(4, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    xfer(1, 1, 32'h1234_5678, 3, 0, 0, 0, 0, 0, 0);
    xfer(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    xfer(2, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    xfer(6, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    xfer(7, 1, 32'h0BAD_F00D, 0, 0, 1, 0, 0, 0, 0);
    xfer(3, 1, 32'hCAFE_0003, 0, 0, 0, 0, 1, 3, 0);
    xfer(3, 0, 0, 2, 0, 0, 1, 0, 0, 0);

    // abort an ACCESS with an asynchronous reset
    s_waits = 10; s_err = 0; s_hang = 0;
    ahb.hsel = 1'b1; ahb.htrans = HT_NONSEQ;
    ahb.haddr = BASE | 32'h14; ahb.hwrite = 1'b0;
    @(posedge clk); #1;
    ahb.hsel = 1'b0; ahb.htrans = HT_IDLE;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_ctl", ctl(), mk(0, HRESP_OKAY, 1, 1));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ctl", ctl(), mk(1, HRESP_OKAY, 0, 0));
    chk("async_rst_hrdata", ahb.hrdata, 32'h0);
    last_rd = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    ahb.hsel = 1'b1; ahb.htrans = HT_IDLE;
    @(negedge clk);
    chk("idle_okay", ctl(), mk(1, HRESP_OKAY, 0, 0));
    @(posedge clk); #1;
    ahb.htrans = HT_BUSY;
    @(negedge clk);
    chk("busy_okay", ctl(), mk(1, HRESP_OKAY, 0, 0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("busy_no_apb", ctl(), mk(1, HRESP_OKAY, 0, 0));
    @(posedge clk); #1;
    ahb.hsel = 1'b0;

    pend = 0;
    cidx = $urandom_range(15);
    cw   = $urandom_range(1);
    for (int i = 0; i < 40; i++) begin
      nidx = $urandom_range(15);
      nw   = $urandom_range(1);
      c    = (i != 39) && ($urandom_range(1) == 1);
      xfer(cidx, 1'(cw), $urandom, $urandom_range(3),
           ($urandom_range(5) == 0), ($urandom_range(7) == 0),
           pend, c, nidx, 1'(nw));
      pend = c;
      cidx = nidx;
      cw   = nw;
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
